// File: rtl/core_pkg.sv
// Shared definitions for the core pipeline: fetch FSM encoding, reset defaults
// and instruction field bit positions used by fetch, decode and the extenders.
package core_pkg;

   localparam int XLEN = 32;

   localparam logic [XLEN-1:0] DEFAULT_RESET_PC  = 32'h0000_0000;
   localparam logic [XLEN-1:0] DEFAULT_NOP_INSTR = 32'h0000_0000;

   // Instruction field positions (MIPS-style I/R formats)
   localparam int OPC_HI = 31;
   localparam int OPC_LO = 26;
   localparam int RS_HI  = 25;
   localparam int RS_LO  = 21;
   localparam int RT_HI  = 20;
   localparam int RT_LO  = 16;
   localparam int RD_HI  = 15;
   localparam int RD_LO  = 11;
   localparam int IMM_HI = 15;
   localparam int IMM_LO = 0;

   // Fetch FSM: requesting, holding a fetched word in the skid, or draining a
   // stale request after a redirect.
   typedef enum logic [1:0] {
      S_REQ   = 2'd0,
      S_HOLD  = 2'd1,
      S_DRAIN = 2'd2
   } fetch_state_t;

   // Word-align a redirect address; the low two bits are ignored.
   function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
      return addr & ~32'h0000_0003;
   endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry holding register for a fetched {instr, pc_plus4} pair that decode
// could not accept in the cycle it arrived.
module fetch_skid_buffer
   import core_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            i_load,
   input  logic            i_clear,
   input  logic [XLEN-1:0] i_instr,
   input  logic [XLEN-1:0] i_pc_plus4,
   output logic            o_valid,
   output logic [XLEN-1:0] o_instr,
   output logic [XLEN-1:0] o_pc_plus4
);

   logic            r_valid;
   logic [XLEN-1:0] r_instr;
   logic [XLEN-1:0] r_pc_plus4;

   // Occupancy flag: load marks the entry full, clear empties it.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_valid <= 1'b1;
      end else if (i_clear) begin
         r_valid <= 1'b0;
      end
   end

   // Payload capture on load.
   // NOTE: payload has no reset; it is only ever read while r_valid is set.
   always_ff @(posedge clk) begin
      if (i_load) begin
         r_instr    <= i_instr;
         r_pc_plus4 <= i_pc_plus4;
      end
   end

   assign o_valid    = r_valid;
   assign o_instr    = r_instr;
   assign o_pc_plus4 = r_pc_plus4;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, requests words from instruction memory
// and fills the IF/ID register, with stall (skid), flush and redirect support.
module fetch_stage
   import core_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC  = DEFAULT_RESET_PC,
   parameter logic [XLEN-1:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            flush,
   input  logic            branch_taken,
   input  logic [XLEN-1:0] branch_target,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [XLEN-1:0] imem_rdata,
   output logic            id_valid,
   output logic [XLEN-1:0] id_instr,
   output logic [XLEN-1:0] id_pc_plus4,
   output logic [5:0]      id_opcode,
   output logic [4:0]      id_rs,
   output logic [4:0]      id_rt,
   output logic [4:0]      id_rd,
   output logic [15:0]     id_imm16
);

   fetch_state_t    r_state, w_state_n;
   logic [XLEN-1:0] r_pc, w_pc_n;
   logic [XLEN-1:0] r_target, w_target_n;
   logic            r_id_valid, w_id_valid_n;
   logic [XLEN-1:0] r_id_instr, w_id_instr_n;
   logic [XLEN-1:0] r_id_pc4, w_id_pc4_n;

   logic            w_req;
   logic            w_ack;
   logic [XLEN-1:0] w_pc_plus4;
   logic [XLEN-1:0] w_target_aligned;
   logic            w_skid_load;
   logic            w_skid_clear;
   logic            w_skid_valid;
   logic [XLEN-1:0] w_skid_instr;
   logic [XLEN-1:0] w_skid_pc4;

   // Requests are suppressed while reset is held; acks outside a request are ignored.
   assign w_req            = !rst && ((r_state == S_REQ) || (r_state == S_DRAIN));
   assign w_ack            = w_req && imem_ack;
   assign w_pc_plus4       = r_pc + 32'd4;
   assign w_target_aligned = align_word(branch_target);

   fetch_skid_buffer u_skid (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_skid_load),
      .i_clear    (w_skid_clear),
      .i_instr    (imem_rdata),
      .i_pc_plus4 (w_pc_plus4),
      .o_valid    (w_skid_valid),
      .o_instr    (w_skid_instr),
      .o_pc_plus4 (w_skid_pc4)
   );

   // State, PC, pending redirect target and IF/ID register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_REQ;
         r_pc       <= RESET_PC;
         r_target   <= '0;
         r_id_valid <= 1'b0;
         r_id_instr <= NOP_INSTR;
         r_id_pc4   <= '0;
      end else begin
         r_state    <= w_state_n;
         r_pc       <= w_pc_n;
         r_target   <= w_target_n;
         r_id_valid <= w_id_valid_n;
         r_id_instr <= w_id_instr_n;
         r_id_pc4   <= w_id_pc4_n;
      end
   end

   // Next-state logic with priority branch_taken > flush > stall > normal.
   // NOTE: every signal gets a default first so no latch is inferred.
   always_comb begin
      w_state_n    = r_state;
      w_pc_n       = r_pc;
      w_target_n   = r_target;
      w_id_valid_n = r_id_valid;
      w_id_instr_n = r_id_instr;
      w_id_pc4_n   = r_id_pc4;
      w_skid_load  = 1'b0;
      w_skid_clear = 1'b0;

      if (branch_taken) begin
         w_id_valid_n = 1'b0;
         w_id_instr_n = NOP_INSTR;
         w_id_pc4_n   = '0;
         w_skid_clear = 1'b1;
         case (r_state)
            S_REQ: begin
               if (w_ack) begin
                  w_pc_n = w_target_aligned;
               end else begin
                  w_state_n  = S_DRAIN;
                  w_target_n = w_target_aligned;
               end
            end
            S_HOLD: begin
               w_pc_n    = w_target_aligned;
               w_state_n = S_REQ;
            end
            S_DRAIN: begin
               if (w_ack) begin
                  w_pc_n    = w_target_aligned;
                  w_state_n = S_REQ;
               end else begin
                  w_target_n = w_target_aligned;
               end
            end
            default: w_state_n = S_REQ;
         endcase
      end else begin
         if (flush) begin
            w_id_valid_n = 1'b0;
            w_id_instr_n = NOP_INSTR;
            w_id_pc4_n   = '0;
         end
         case (r_state)
            S_REQ: begin
               if (w_ack) begin
                  w_pc_n = w_pc_plus4;
                  if (stall || flush) begin
                     // Decode cannot take it (or is being flushed): park it.
                     w_skid_load = 1'b1;
                     w_state_n   = S_HOLD;
                  end else begin
                     w_id_valid_n = 1'b1;
                     w_id_instr_n = imem_rdata;
                     w_id_pc4_n   = w_pc_plus4;
                  end
               end
            end
            S_HOLD: begin
               if (!stall && !flush && w_skid_valid) begin
                  w_id_valid_n = 1'b1;
                  w_id_instr_n = w_skid_instr;
                  w_id_pc4_n   = w_skid_pc4;
                  w_skid_clear = 1'b1;
                  w_state_n    = S_REQ;
               end
            end
            S_DRAIN: begin
               // Stale response is dropped; resume at the redirect target.
               if (w_ack) begin
                  w_pc_n    = r_target;
                  w_state_n = S_REQ;
               end
            end
            default: w_state_n = S_REQ;
         endcase
      end
   end

   assign imem_req    = w_req;
   assign imem_addr   = r_pc;
   assign id_valid    = r_id_valid;
   assign id_instr    = r_id_instr;
   assign id_pc_plus4 = r_id_pc4;

   // Fields read as zero for a bubble regardless of the NOP encoding.
   assign id_opcode = r_id_valid ? r_id_instr[OPC_HI:OPC_LO] : '0;
   assign id_rs     = r_id_valid ? r_id_instr[RS_HI:RS_LO]   : '0;
   assign id_rt     = r_id_valid ? r_id_instr[RT_HI:RT_LO]   : '0;
   assign id_rd     = r_id_valid ? r_id_instr[RD_HI:RD_LO]   : '0;
   assign id_imm16  = r_id_valid ? r_id_instr[IMM_HI:IMM_LO] : '0;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized
// run, all compared against a transaction-level reference model.
module tb_fetch_stage;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        flush;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        id_valid;
   logic [31:0] id_instr;
   logic [31:0] id_pc_plus4;
   logic [5:0]  id_opcode;
   logic [4:0]  id_rs;
   logic [4:0]  id_rt;
   logic [4:0]  id_rd;
   logic [15:0] id_imm16;

   int vectors     = 0;
   int miscompares = 0;

   fetch_stage #(
      .RESET_PC  (32'h0000_0000),
      .NOP_INSTR (32'h0000_0000)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .stall         (stall),
      .flush         (flush),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ack      (imem_ack),
      .imem_rdata    (imem_rdata),
      .id_valid      (id_valid),
      .id_instr      (id_instr),
      .id_pc_plus4   (id_pc_plus4),
      .id_opcode     (id_opcode),
      .id_rs         (id_rs),
      .id_rt         (id_rt),
      .id_rd         (id_rd),
      .id_imm16      (id_imm16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc4;
   } fetched_t;

   typedef struct packed {
      logic        valid;
      logic [31:0] instr;
      logic [31:0] pc4;
   } ifid_t;

   typedef struct packed {
      logic        req;
      logic [31:0] addr;
      logic        valid;
      logic [31:0] instr;
      logic [31:0] pc4;
      logic [5:0]  opc;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [15:0] imm;
   } snap_t;

   localparam ifid_t BUBBLE = '{valid: 1'b0, instr: 32'h0, pc4: 32'h0};

   logic [31:0] m_pc;        // address the fetcher is (or will be) requesting
   fetched_t    m_held[$];   // fetched word waiting for decode
   logic [31:0] m_redirect[$]; // redirect waiting for a stale response
   ifid_t       m_id;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0: return 32'h3C01_ABCD;
         32'h4: return 32'h3402_FFFF;
         32'h8: return 32'h2003_0010;
         default: return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
      endcase
   endfunction

   task automatic model_step(input logic r, input logic s, input logic f, input logic b,
                             input logic [31:0] t, input logic ack_taken,
                             input logic [31:0] rdata);
      logic [31:0] aligned;
      fetched_t    item;
      aligned = t & 32'hFFFF_FFFC;
      if (r) begin
         m_pc = 32'h0;
         m_held.delete();
         m_redirect.delete();
         m_id = BUBBLE;
      end else if (b) begin
         m_id = BUBBLE;
         if (m_redirect.size() != 0) begin
            if (ack_taken) begin
               m_pc = aligned;
               m_redirect.delete();
            end else begin
               m_redirect[0] = aligned;
            end
         end else if (m_held.size() != 0) begin
            m_held.delete();
            m_pc = aligned;
         end else if (ack_taken) begin
            m_pc = aligned;
         end else begin
            m_redirect.push_back(aligned);
         end
      end else begin
         if (f) m_id = BUBBLE;
         if (m_redirect.size() != 0) begin
            if (ack_taken) m_pc = m_redirect.pop_front();
         end else if (ack_taken) begin
            item = '{instr: rdata, pc4: m_pc + 32'd4};
            m_pc = m_pc + 32'd4;
            if (s || f) m_held.push_back(item);
            else        m_id = '{valid: 1'b1, instr: item.instr, pc4: item.pc4};
         end else if (m_held.size() != 0 && !s && !f) begin
            item = m_held.pop_front();
            m_id = '{valid: 1'b1, instr: item.instr, pc4: item.pc4};
         end
      end
   endtask

   function automatic snap_t exp_snap();
      snap_t e;
      e.req   = !rst && (m_held.size() == 0);
      e.addr  = m_pc;
      e.valid = m_id.valid;
      e.instr = m_id.instr;
      e.pc4   = m_id.pc4;
      e.opc   = m_id.instr[31:26];
      e.rs    = m_id.instr[25:21];
      e.rt    = m_id.instr[20:16];
      e.rd    = m_id.instr[15:11];
      e.imm   = m_id.instr[15:0];
      return e;
   endfunction

   function automatic snap_t dut_snap();
      return '{req: imem_req, addr: imem_addr, valid: id_valid, instr: id_instr,
               pc4: id_pc_plus4, opc: id_opcode, rs: id_rs, rt: id_rt, rd: id_rd,
               imm: id_imm16};
   endfunction

   // One clock: drive inputs, let memory respond, advance model, sample #1 after edge.
   task automatic cycle(input logic r, input logic s, input logic f, input logic b,
                        input logic [31:0] t, input logic a);
      logic m_req;
      rst           = r;
      stall         = s;
      flush         = f;
      branch_taken  = b;
      branch_target = t;
      m_req         = !r && (m_held.size() == 0);
      imem_ack      = a;
      imem_rdata    = a ? mem_word(m_pc) : $urandom();
      model_step(r, s, f, b, t, a && m_req, imem_rdata);
      @(posedge clk);
      #1;
      imem_ack = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
         vectors++;
         if ({imem_req, imem_addr, id_valid, id_instr} !== {1'b0, 32'h0, 1'b0, 32'h0}) begin
            miscompares++;
            $display("FAIL reset[%0d]: req=%b addr=%h valid=%b instr=%h, want 0/0/0/0",
                     i, imem_req, imem_addr, id_valid, id_instr);
         end
      end
      rst = 1'b0;
      #1;
      vectors++;
      if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
         miscompares++;
         $display("FAIL reset_release: req=%b addr=%h, want 1/00000000", imem_req, imem_addr);
      end
   endtask

   task automatic test_zero_wait();
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      vectors++;
      if ({id_instr, id_opcode, id_rt, id_imm16, id_pc_plus4} !==
          {32'h3C01_ABCD, 6'h0F, 5'd1, 16'hABCD, 32'h4}) begin
         miscompares++;
         $display("FAIL zero_wait.first: instr=%h opc=%h rt=%0d imm=%h pc4=%h",
                  id_instr, id_opcode, id_rt, id_imm16, id_pc_plus4);
      end
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      vectors++;
      if ({id_imm16, id_pc_plus4, imem_addr} !== {16'hFFFF, 32'h8, 32'h8}) begin
         miscompares++;
         $display("FAIL zero_wait.second: imm=%h pc4=%h addr=%h, want FFFF/8/8",
                  id_imm16, id_pc_plus4, imem_addr);
      end
      vectors++;
      if (dut_snap() !== exp_snap()) begin
         miscompares++;
         $display("FAIL zero_wait.model: got %h want %h", dut_snap(), exp_snap());
      end
   endtask

   task automatic test_stall_skid();
      for (int i = 0; i < 4; i++) begin
         cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, (i == 0));
         vectors++;
         if ({imem_req, id_instr, id_pc_plus4} !== {1'b0, 32'h3402_FFFF, 32'h8}) begin
            miscompares++;
            $display("FAIL stall[%0d]: req=%b instr=%h pc4=%h, want 0/3402FFFF/8",
                     i, imem_req, id_instr, id_pc_plus4);
         end
      end
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      vectors++;
      if ({id_instr, id_imm16, imem_req, imem_addr} !== {32'h2003_0010, 16'h0010, 1'b1, 32'hC}) begin
         miscompares++;
         $display("FAIL stall_release: instr=%h imm=%h req=%b addr=%h",
                  id_instr, id_imm16, imem_req, imem_addr);
      end
   endtask

   task automatic test_branch_drain();
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 1'b0, 1'b0, (i == 0), 32'h0000_0043, 1'b0);
         vectors++;
         if ({imem_req, imem_addr, id_valid} !== {1'b1, 32'hC, 1'b0}) begin
            miscompares++;
            $display("FAIL drain_wait[%0d]: req=%b addr=%h valid=%b, want 1/0000000C/0",
                     i, imem_req, imem_addr, id_valid);
         end
      end
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      vectors++;
      if ({imem_req, imem_addr, id_valid} !== {1'b1, 32'h40, 1'b0}) begin
         miscompares++;
         $display("FAIL drain_done: req=%b addr=%h valid=%b, want 1/00000040/0",
                  imem_req, imem_addr, id_valid);
      end
   endtask

   task automatic test_branch_stall();
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      vectors++;
      if (dut_snap() !== exp_snap()) begin
         miscompares++;
         $display("FAIL branch_stall.pre: got %h want %h", dut_snap(), exp_snap());
      end
      cycle(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0100, 1'b1);
      vectors++;
      if ({imem_addr, id_valid, imem_req} !== {32'h100, 1'b0, 1'b1}) begin
         miscompares++;
         $display("FAIL branch_stall: addr=%h valid=%b req=%b, want 00000100/0/1",
                  imem_addr, id_valid, imem_req);
      end
   endtask

   task automatic test_flush_and_reset();
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      vectors++;
      if ({id_valid, id_instr, id_imm16, imem_req, imem_addr} !==
          {1'b0, 32'h0, 16'h0, 1'b1, 32'h104}) begin
         miscompares++;
         $display("FAIL flush_no_ack: valid=%b instr=%h imm=%h req=%b addr=%h",
                  id_valid, id_instr, id_imm16, imem_req, imem_addr);
      end
      // flush coinciding with ack: word is parked, then delivered
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
      vectors++;
      if (dut_snap() !== exp_snap()) begin
         miscompares++;
         $display("FAIL flush_ack.park: got %h want %h", dut_snap(), exp_snap());
      end
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      vectors++;
      if ({id_valid, id_instr, id_pc_plus4} !== {1'b1, mem_word(32'h104), 32'h108}) begin
         miscompares++;
         $display("FAIL flush_ack.deliver: valid=%b instr=%h pc4=%h",
                  id_valid, id_instr, id_pc_plus4);
      end
      // reset while draining; acks during reset must be ignored
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0200, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      vectors++;
      if ({imem_req, imem_addr, id_valid} !== {1'b0, 32'h0, 1'b0}) begin
         miscompares++;
         $display("FAIL reset_in_drain: req=%b addr=%h valid=%b, want 0/0/0",
                  imem_req, imem_addr, id_valid);
      end
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      vectors++;
      if ({id_valid, id_instr, id_pc_plus4} !== {1'b1, 32'h3C01_ABCD, 32'h4}) begin
         miscompares++;
         $display("FAIL reset_recover: valid=%b instr=%h pc4=%h",
                  id_valid, id_instr, id_pc_plus4);
      end
   endtask

   task automatic test_pc_wrap();
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1);
      vectors++;
      if (imem_addr !== 32'hFFFF_FFFC) begin
         miscompares++;
         $display("FAIL wrap.target: addr=%h want FFFFFFFC", imem_addr);
      end
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      vectors++;
      if ({id_pc_plus4, imem_addr, id_instr} !== {32'h0, 32'h0, mem_word(32'hFFFF_FFFC)}) begin
         miscompares++;
         $display("FAIL wrap: pc4=%h addr=%h instr=%h", id_pc_plus4, imem_addr, id_instr);
      end
   endtask

   task automatic test_random();
      logic r, s, f, b, a;
      for (int i = 0; i < 400; i++) begin
         r = ($urandom_range(0, 99) == 0);
         s = ($urandom_range(0, 3) == 0);
         f = ($urandom_range(0, 9) == 0);
         b = ($urandom_range(0, 11) == 0);
         a = ($urandom_range(0, 2) != 0);
         cycle(r, s, f, b, $urandom(), a);
         vectors++;
         if (dut_snap() !== exp_snap()) begin
            miscompares++;
            $display("FAIL random[%0d]: got %h want %h", i, dut_snap(), exp_snap());
         end
      end
   endtask

   initial begin
      rst           = 1'b1;
      stall         = 1'b0;
      flush         = 1'b0;
      branch_taken  = 1'b0;
      branch_target = 32'h0;
      imem_ack      = 1'b0;
      imem_rdata    = 32'h0;
      m_pc          = 32'h0;
      m_id          = BUBBLE;

      test_reset();
      test_zero_wait();
      test_stall_skid();
      test_branch_drain();
      test_branch_stall();
      test_flush_and_reset();
      test_pc_wrap();
      test_random();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
